division: RTL and testbench



---
 rtl/division_pkg.sv | 34 +++
 rtl/division_if.sv | 33 +++
 rtl/division_step.sv | 36 +++
 rtl/division.sv | 161 ++++++++++++++++
 tb/tb_division.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/division_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : division_pkg
//  Purpose  : Shared state encoding, enum type and counter-width helper for
//             the multi-cycle restoring divider.
//  Revision : 1.0 - initial release
// ============================================================================
package division_pkg;

  // Default operand width of the MIPS HI/LO path.
  localparam int DIV_BITS_DFLT = 32;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_FIX  = ST_FIX,
    S_DONE = ST_DONE
  } state_t;

  // Iteration counter must hold the value BITS itself.
  function automatic int cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

  localparam int CNT_W = cnt_width(DIV_BITS_DFLT);

endpackage : division_pkg
`default_nettype wire

// File: rtl/division_if.sv
`default_nettype none
// ============================================================================
//  Module   : division_if
//  Purpose  : Request/result bundle between pipeline control and the divider.
//             master = requester (control), slave = divider.
//  Revision : 1.0 - initial release
// ============================================================================
interface division_if #(
  parameter int BITS = 32
);

  logic            start;
  logic [BITS-1:0] dividend;
  logic [BITS-1:0] divisor;
  logic            unsigned_instr;
  logic [BITS-1:0] quotient;
  logic [BITS-1:0] remainder;
  logic            busy;
  logic            done;
  logic            div_by_zero;

  modport master (
    output start, dividend, divisor, unsigned_instr,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor, unsigned_instr,
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface : division_if
`default_nettype wire

// File: rtl/division_step.sv
`default_nettype none
// ============================================================================
//  Module   : division_step
//  Purpose  : One combinational restoring-division iteration. Shifts
//             {rem, quo} left by one, trial-subtracts the divisor magnitude
//             at BITS+1 width and sets the new quotient LSB.
//  Revision : 1.0 - initial release
// ============================================================================
module division_step #(
  parameter int BITS = 32
) (
  input  wire logic [BITS-1:0] i_rem,
  input  wire logic [BITS-1:0] i_quo,
  input  wire logic [BITS-1:0] i_dmag,
  output logic      [BITS-1:0] o_rem,
  output logic      [BITS-1:0] o_quo
);

  logic [BITS:0] w_shift;
  logic [BITS:0] w_dext;
  logic [BITS:0] w_diff;
  logic          w_ge;

  // Shift in the next dividend bit and trial-subtract; the partial
  // remainder is always below the divisor, so the result fits BITS bits.
  always_comb begin
    w_shift = {i_rem, i_quo[BITS-1]};
    w_dext  = {1'b0, i_dmag};
    w_diff  = w_shift - w_dext;
    w_ge    = (w_shift >= w_dext);
    o_rem   = w_ge ? w_diff[BITS-1:0] : w_shift[BITS-1:0];
    o_quo   = {i_quo[BITS-2:0], w_ge};
  end

endmodule : division_step
`default_nettype wire

// File: rtl/division.sv
`default_nettype none
// ============================================================================
//  Module   : division
//  Purpose  : Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
//             Quotient goes to LO, remainder to HI. One quotient bit per
//             clock; signs are stripped on entry and restored in FIX.
//             BITS must be at least 2.
//  Revision : 1.0 - initial release
// ============================================================================
module division
  import division_pkg::*;
#(
  parameter int BITS = 32
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  division_if.slave  bus
);

  localparam int                 c_CNT_W    = cnt_width(BITS);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(BITS);

  state_t             r_state;
  state_t             w_state_nxt;

  logic [BITS-1:0]    r_rem;        // partial remainder
  logic [BITS-1:0]    r_quo;        // dividend shifting out / quotient in
  logic [BITS-1:0]    r_dmag;       // divisor magnitude
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_qneg;
  logic               r_rneg;
  logic [BITS-1:0]    r_quotient;
  logic [BITS-1:0]    r_remainder;
  logic               r_dbz;

  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic [BITS-1:0]    w_dvd_mag;
  logic [BITS-1:0]    w_dvs_mag;
  logic               w_dvs_zero;
  logic [BITS-1:0]    w_rem_nxt;
  logic [BITS-1:0]    w_quo_nxt;
  logic               w_busy;
  logic               w_done;

  // Operand sign detection and absolute value; unsigned mode passes through.
  always_comb begin
    w_dvd_neg  = ~bus.unsigned_instr & bus.dividend[BITS-1];
    w_dvs_neg  = ~bus.unsigned_instr & bus.divisor[BITS-1];
    w_dvd_mag  = w_dvd_neg ? -bus.dividend : bus.dividend;
    w_dvs_mag  = w_dvs_neg ? -bus.divisor  : bus.divisor;
    w_dvs_zero = (bus.divisor == '0);
  end

  division_step #(
    .BITS (BITS)
  ) u_step (
    .i_rem  (r_rem),
    .i_quo  (r_quo),
    .i_dmag (r_dmag),
    .o_rem  (w_rem_nxt),
    .o_quo  (w_quo_nxt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status decode; start is only honoured in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_state_nxt = w_dvs_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == c_CNT_ONE) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_dmag      <= '0;
      r_cnt       <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rem  <= '0;
            r_quo  <= w_dvd_mag;
            r_dmag <= w_dvs_mag;
            r_cnt  <= c_CNT_LOAD;
            r_qneg <= w_dvd_neg ^ w_dvs_neg;
            r_rneg <= w_dvd_neg;
            r_dbz  <= w_dvs_zero;
            // Divide by zero bypasses the iteration: all-ones quotient,
            // raw dividend as remainder, identical for DIV and DIVU.
            if (w_dvs_zero) begin
              r_quotient  <= '1;
              r_remainder <= bus.dividend;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - c_CNT_ONE;
        end
        S_FIX: begin
          // Quotient truncates toward zero; remainder follows dividend sign.
          // Most-negative / -1 lands on the most-negative value naturally.
          r_quotient  <= r_qneg ? -r_quo : r_quo;
          r_remainder <= r_rneg ? -r_rem : r_rem;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.div_by_zero = r_dbz;

endmodule : division
`default_nettype wire

// File: tb/tb_division.sv
`default_nettype none
// ============================================================================
//  Module   : tb_division
//  Purpose  : Directed self-checking bench for the restoring divider.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_division;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   lat;
  int   pulses;
  logic [31:0] cap_q;
  logic [31:0] cap_r;

  division_if #(.BITS(32)) bus ();

  division #(.BITS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] dvd, input logic [31:0] dvs, input logic uns);
    bus.start          = 1'b1;
    bus.dividend       = dvd;
    bus.divisor        = dvs;
    bus.unsigned_instr = uns;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Cycles after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.done && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                     input logic uns, input logic [31:0] eq, input logic [31:0] er,
                     input logic edbz, input int elat);
    int l;
    issue(dvd, dvs, uns);
    chk({tag, ".busy_after_start"}, 32'(bus.busy), 32'd1);
    wait_done(l);
    chk({tag, ".latency"}, 32'(l), 32'(elat));
    chk({tag, ".quotient"}, bus.quotient, eq);
    chk({tag, ".remainder"}, bus.remainder, er);
    chk({tag, ".div_by_zero"}, 32'(bus.div_by_zero), 32'(edbz));
    chk({tag, ".busy_in_done"}, 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, ".done_cleared"}, 32'(bus.done), 32'd0);
    chk({tag, ".busy_cleared"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_chk              = 0;
    n_err              = 0;
    rst_n              = 1'b0;
    bus.start          = 1'b0;
    bus.dividend       = '0;
    bus.divisor        = '0;
    bus.unsigned_instr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.quotient", bus.quotient, 32'h0);
    chk("reset.remainder", bus.remainder, 32'h0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain unsigned and signed divisions.
    run("divu_100_7",   32'd100,       32'd7,         1'b1, 32'd14,        32'd2,         1'b0, 33);
    run("div_m7_2",     32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run("divu_m7_2",    32'hFFFF_FFF9, 32'd2,         1'b1, 32'h7FFF_FFFC, 32'd1,         1'b0, 33);
    run("div_100_m7",   32'd100,       32'hFFFF_FFF9, 1'b0, 32'hFFFF_FFF2, 32'd2,         1'b0, 33);
    run("div_m100_m7",  32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, 32'd14,        32'hFFFF_FFFE, 1'b0, 33);
    run("divu_max_1",   32'hFFFF_FFFF, 32'd1,         1'b1, 32'hFFFF_FFFF, 32'd0,         1'b0, 33);
    run("div_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'd0,         1'b0, 33);

    // Divide by zero: done in the cycle after the accepting edge.
    run("divu_by_zero", 32'h0000_1234, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 0);
    run("div_by_zero",  32'hFFFF_FFFB, 32'd0,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 0);

    // Start while busy is ignored; div_by_zero clears on the new start.
    issue(32'd100, 32'd7, 1'b1);
    chk("busy_start.dbz_cleared", 32'(bus.div_by_zero), 32'd0);
    pulses = 0;
    cap_q  = '0;
    cap_r  = '0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        pulses++;
        cap_q = bus.quotient;
        cap_r = bus.remainder;
      end
    end
    chk("busy_start.pulses", 32'(pulses), 32'd1);
    chk("busy_start.quotient", cap_q, 32'd14);
    chk("busy_start.remainder", cap_r, 32'd2);

    // Start presented during the DONE cycle is not accepted.
    issue(32'd100, 32'd7, 1'b1);
    wait_done(lat);
    chk("done_start.latency", 32'(lat), 32'd33);
    bus.start    = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("done_start.busy", 32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_start.still_idle", 32'(bus.busy), 32'd0);
    chk("done_start.quotient_held", bus.quotient, 32'd14);

    // Reset mid-operation abandons the division.
    issue(32'd100, 32'd7, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midreset.quotient", bus.quotient, 32'h0);
    chk("midreset.remainder", bus.remainder, 32'h0);
    chk("midreset.busy", 32'(bus.busy), 32'd0);
    chk("midreset.done", 32'(bus.done), 32'd0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk("midreset.no_done", 32'(pulses), 32'd0);
    run("after_reset_9_3", 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, 33);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule : tb_division
`default_nettype wire
